// File: rtl/pipe_mem_wb.sv
// rtl/pipe_mem_wb.sv - MEM/WB pipeline stage with valid/ready handshake and one-entry skid buffer
//
// Selects the register-file write-back value (load data or exe result) and
// holds it for the write-back stage. An OUT slot drives the outputs and a SKID
// slot absorbs the one instruction MEM may hand over in the cycle WB stalls,
// so o_ready is a flop and never depends combinationally on i_ready.
//
// Optional feature macro: PIPE_MEM_WB_FWD_EN adds the o_fwd_* bypass outputs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_valid / o_ready     upstream handshake (MEM -> this stage)
//   i_flush               synchronous kill of OUT and SKID entries
//   i_rf_wena, i_rf_waddr destination write enable / register
//   i_sel_mem             1: write i_DMEM_rdata, 0: write i_exe_out
//   i_DMEM_rdata          extended load data
//   i_exe_out             ALU/exe result
//   o_valid / i_ready     downstream handshake (this stage -> WB)
//   o_rf_wena/waddr/wdata write-back entry held in OUT
//   o_fwd_wena/waddr/wdata youngest pending write (PIPE_MEM_WB_FWD_EN only)

module pipe_mem_wb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_flush,
    input  logic          i_rf_wena,
    input  logic [AW-1:0] i_rf_waddr,
    input  logic          i_sel_mem,
    input  logic [DW-1:0] i_DMEM_rdata,
    input  logic [DW-1:0] i_exe_out,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_rf_wena,
    output logic [AW-1:0] o_rf_waddr,
`ifdef PIPE_MEM_WB_FWD_EN
    output logic [DW-1:0] o_rf_wdata,
    output logic          o_fwd_wena,
    output logic [AW-1:0] o_fwd_waddr,
    output logic [DW-1:0] o_fwd_wdata
`else
    output logic [DW-1:0] o_rf_wdata
`endif
);

    logic          out_valid;
    logic          out_wena;
    logic [AW-1:0] out_waddr;
    logic [DW-1:0] out_wdata;

    logic          skid_valid;
    logic          skid_wena;
    logic [AW-1:0] skid_waddr;
    logic [DW-1:0] skid_wdata;

    logic          in_wena;
    logic [DW-1:0] in_wdata;
    logic          accept;
    logic          drain;

    // $zero is never written: drop the enable at capture time.
    assign in_wena  = i_rf_wena && (i_rf_waddr != '0);
    assign in_wdata = i_sel_mem ? i_DMEM_rdata : i_exe_out;

    // o_ready is just the inverted SKID valid flop, so it is registered.
    assign o_ready = !skid_valid;
    assign accept  = i_valid && o_ready;
    assign drain   = out_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_wena   <= 1'b0;
            out_waddr  <= '0;
            out_wdata  <= '0;
            skid_valid <= 1'b0;
            skid_wena  <= 1'b0;
            skid_waddr <= '0;
            skid_wdata <= '0;
        end else if (i_flush) begin
            // Data registers keep stale contents; only the valid flags matter.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                // Older SKID entry leaves first to preserve order.
                out_valid  <= 1'b1;
                out_wena   <= skid_wena;
                out_waddr  <= skid_waddr;
                out_wdata  <= skid_wdata;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_wena  <= in_wena;
                out_waddr <= i_rf_waddr;
                out_wdata <= in_wdata;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // OUT is stalled; accept can only happen with SKID empty.
            skid_valid <= 1'b1;
            skid_wena  <= in_wena;
            skid_waddr <= i_rf_waddr;
            skid_wdata <= in_wdata;
        end
    end

    assign o_valid    = out_valid;
    assign o_rf_wena  = out_valid && out_wena;
    assign o_rf_waddr = out_waddr;
    assign o_rf_wdata = out_wdata;

`ifdef PIPE_MEM_WB_FWD_EN
    // The SKID entry is always younger than OUT, so it wins the bypass.
    always_comb begin
        o_fwd_wena  = out_valid && out_wena;
        o_fwd_waddr = out_waddr;
        o_fwd_wdata = out_wdata;
        if (skid_valid) begin
            o_fwd_wena  = skid_wena;
            o_fwd_waddr = skid_waddr;
            o_fwd_wdata = skid_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mem_wb.sv
// tb/tb_pipe_mem_wb.sv - directed self-checking bench for pipe_mem_wb

module tb_pipe_mem_wb;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_flush;
    logic        i_rf_wena;
    logic [4:0]  i_rf_waddr;
    logic        i_sel_mem;
    logic [31:0] i_DMEM_rdata;
    logic [31:0] i_exe_out;
    logic        o_valid;
    logic        i_ready;
    logic        o_rf_wena;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
`ifdef PIPE_MEM_WB_FWD_EN
    logic        o_fwd_wena;
    logic [4:0]  o_fwd_waddr;
    logic [31:0] o_fwd_wdata;
`endif

    int n_vec;
    int n_err;
    int commit_n;
    logic [4:0]  commit_addr [0:15];
    logic [31:0] commit_data [0:15];

    pipe_mem_wb #(.DW(32), .AW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .i_rf_wena    (i_rf_wena),
        .i_rf_waddr   (i_rf_waddr),
        .i_sel_mem    (i_sel_mem),
        .i_DMEM_rdata (i_DMEM_rdata),
        .i_exe_out    (i_exe_out),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_rf_wena    (o_rf_wena),
        .o_rf_waddr   (o_rf_waddr),
`ifdef PIPE_MEM_WB_FWD_EN
        .o_rf_wdata   (o_rf_wdata),
        .o_fwd_wena   (o_fwd_wena),
        .o_fwd_waddr  (o_fwd_waddr),
        .o_fwd_wdata  (o_fwd_wdata)
`else
        .o_rf_wdata   (o_rf_wdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file write log: a commit is a handshake with o_rf_wena high.
    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready && o_rf_wena && commit_n < 16) begin
            commit_addr[commit_n] = o_rf_waddr;
            commit_data[commit_n] = o_rf_wdata;
            commit_n = commit_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic sel,
                         input logic [31:0] ld, input logic [31:0] ex);
        i_valid      = v;
        i_rf_wena    = 1'b1;
        i_rf_waddr   = a;
        i_sel_mem    = sel;
        i_DMEM_rdata = ld;
        i_exe_out    = ex;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic we,
                           input logic [4:0] a, input logic [31:0] d, input logic rdy);
        chk({tag, ".valid"}, {31'd0, o_valid},   {31'd0, v});
        chk({tag, ".wena"},  {31'd0, o_rf_wena}, {31'd0, we});
        chk({tag, ".waddr"}, {27'd0, o_rf_waddr}, {27'd0, a});
        chk({tag, ".wdata"}, o_rf_wdata, d);
        chk({tag, ".ready"}, {31'd0, o_ready},   {31'd0, rdy});
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        commit_n = 0;
        rst_n    = 1'b0;
        i_flush  = 1'b0;
        i_ready  = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);

        // Reset state
        #12;
        chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
`ifdef PIPE_MEM_WB_FWD_EN
        chk("reset.fwd_wena",  {31'd0, o_fwd_wena},  32'd0);
        chk("reset.fwd_waddr", {27'd0, o_fwd_waddr}, 32'd0);
        chk("reset.fwd_wdata", o_fwd_wdata,          32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("idle", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);

        // Streaming with i_ready=1
        drive(1'b1, 5'd3, 1'b0, 32'hDEAD_BEEF, 32'h11);
        tick();
        chk_out("stream0", 1'b1, 1'b1, 5'd3, 32'h11, 1'b1);
        drive(1'b1, 5'd4, 1'b1, 32'hFFFF_FF80, 32'h22);
        tick();
        chk_out("stream1", 1'b1, 1'b1, 5'd4, 32'hFFFF_FF80, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("stream_empty.valid", {31'd0, o_valid}, 32'd0);
        chk("stream.commits", commit_n, 2);

        // Stall: A then B into SKID; C waits while o_ready is low
        i_ready = 1'b0;
        drive(1'b1, 5'd5, 1'b0, 32'h0, 32'hA);
        tick();
        chk_out("stallA", 1'b1, 1'b1, 5'd5, 32'hA, 1'b1);
        drive(1'b1, 5'd6, 1'b0, 32'h0, 32'hB);
        tick();
        chk_out("stallB", 1'b1, 1'b1, 5'd5, 32'hA, 1'b0);
`ifdef PIPE_MEM_WB_FWD_EN
        chk("fwd_stall.wena",  {31'd0, o_fwd_wena},  32'd1);
        chk("fwd_stall.waddr", {27'd0, o_fwd_waddr}, 32'd6);
        chk("fwd_stall.wdata", o_fwd_wdata,          32'hB);
`endif
        drive(1'b1, 5'd7, 1'b0, 32'h0, 32'hC);
        tick();
        chk_out("stall_hold", 1'b1, 1'b1, 5'd5, 32'hA, 1'b0);
        i_ready = 1'b1;
        tick();
        chk_out("release", 1'b1, 1'b1, 5'd6, 32'hB, 1'b1);
`ifdef PIPE_MEM_WB_FWD_EN
        chk("fwd_release.wena",  {31'd0, o_fwd_wena},  32'd1);
        chk("fwd_release.waddr", {27'd0, o_fwd_waddr}, 32'd6);
        chk("fwd_release.wdata", o_fwd_wdata,          32'hB);
`endif
        tick();
        chk_out("after_release", 1'b1, 1'b1, 5'd7, 32'hC, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("stall_empty.valid", {31'd0, o_valid}, 32'd0);
        chk("stall.commits", commit_n, 5);
        chk("commit2.addr", {27'd0, commit_addr[2]}, 32'd5);
        chk("commit3.addr", {27'd0, commit_addr[3]}, 32'd6);
        chk("commit4.addr", {27'd0, commit_addr[4]}, 32'd7);
        chk("commit4.data", commit_data[4], 32'hC);

        // Flush with OUT and SKID full, no drain
        i_ready = 1'b0;
        drive(1'b1, 5'd8, 1'b0, 32'h0, 32'hD);
        tick();
        drive(1'b1, 5'd9, 1'b0, 32'h0, 32'hE);
        tick();
        chk("preflush.ready", {31'd0, o_ready}, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush.valid", {31'd0, o_valid},   32'd0);
        chk("flush.wena",  {31'd0, o_rf_wena}, 32'd0);
        chk("flush.ready", {31'd0, o_ready},   32'd1);
        chk("flush.commits", commit_n, 5);
        i_ready = 1'b1;
        tick();
        chk("postflush.valid", {31'd0, o_valid}, 32'd0);

        // Flush together with drain: the drained entry still commits
        drive(1'b1, 5'd10, 1'b0, 32'h0, 32'hF);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flushdrain.valid", {31'd0, o_valid}, 32'd0);
        chk("flushdrain.commits", commit_n, 6);
        chk("flushdrain.addr", {27'd0, commit_addr[5]}, 32'd10);

        // Write to $zero never enables the register file
        i_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 32'h0, 32'h1234);
        tick();
        chk_out("zero", 1'b1, 1'b0, 5'd0, 32'h1234, 1'b1);

        // Asynchronous reset mid-stall
        drive(1'b1, 5'd11, 1'b0, 32'h0, 32'h77);
        tick();
        chk("prereset.ready", {31'd0, o_ready}, 32'd0);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("final.commits", commit_n, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
